// File: rtl/apb_requester_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// apb_requester_if: command/response handshake plus APB completer bus. Rev 1.0
// -----------------------------------------------------------------------------
interface apb_requester_if #(
  parameter int dataBits  = 8,
  parameter int addrWidth = 2
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [addrWidth-1:0] cmd_addr;
  logic [dataBits-1:0]  cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [dataBits-1:0]  rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;
  logic                 sel;
  logic                 enable;
  logic                 write;
  logic [addrWidth-1:0] addr;
  logic [dataBits-1:0]  wdata;
  logic [dataBits-1:0]  rdata;
  logic                 ready;
  logic                 slverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata, ready, slverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           sel, enable, write, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata, ready, slverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           sel, enable, write, addr, wdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// -----------------------------------------------------------------------------
// apb_requester: one command -> one APB transfer -> one response. Rev 1.0
// -----------------------------------------------------------------------------
module apb_requester #(
  parameter int dataBits      = 8,
  parameter int addrWidth     = 2,
  parameter int timeoutCycles = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  apb_requester_if.master bus
);
  localparam int CW = $clog2(timeoutCycles + 1);
  localparam logic [CW-1:0] c_WAIT_LIMIT = CW'(timeoutCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        wait_q;
  logic                 cmd_ready_q;
  logic                 sel_q;
  logic                 enable_q;
  logic                 write_q;
  logic [addrWidth-1:0] addr_q;
  logic [dataBits-1:0]  wdata_q;
  logic                 rsp_valid_q;
  logic [dataBits-1:0]  rsp_rdata_q;
  logic                 rsp_err_q;
  logic                 rsp_timeout_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      cmd_ready_q   <= 1'b0;
      sel_q         <= 1'b0;
      enable_q      <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            sel_q       <= 1'b1;
            write_q     <= bus.cmd_write;
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            wait_q      <= '0;
            state_q     <= S_SETUP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_SETUP: begin
          enable_q <= 1'b1;
          state_q  <= S_ACCESS;
        end
        S_ACCESS: begin
          // A completion on the last allowed cycle wins over the watchdog.
          if (bus.ready) begin
            rsp_rdata_q   <= write_q ? '0 : bus.rdata;
            rsp_err_q     <= bus.slverr;
            rsp_timeout_q <= 1'b0;
          end else if (wait_q == c_WAIT_LIMIT) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
          if (bus.ready || (wait_q == c_WAIT_LIMIT)) begin
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b0;
          sel_q       <= 1'b0;
          enable_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.sel         = sel_q;
  assign bus.enable      = enable_q;
  assign bus.write       = write_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_apb_requester: scoreboard bench with a behavioural completer. Rev 1.0
// -----------------------------------------------------------------------------
module tb_apb_requester;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  apb_requester_if #(.dataBits(8), .addrWidth(2)) bus ();

  apb_requester #(.dataBits(8), .addrWidth(2), .timeoutCycles(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         acc;
    int         acc_at;
  } exp_t;

  typedef struct {
    int         wn;
    logic [7:0] rd;
    logic       se;
  } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rr_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Response consumer: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Completer: holds ready low for cur.wn ACCESS cycles, junk elsewhere
  initial begin
    cfg_t cur;
    int   k;
    cur = '{wn: 0, rd: 8'h00, se: 1'b0};
    k = 0;
    bus.ready = 1'b0;
    bus.rdata = 8'h00;
    bus.slverr = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.sel && bus.enable) begin
        bus.ready  = (k == cur.wn);
        bus.rdata  = bus.ready ? cur.rd : 8'($urandom);
        bus.slverr = bus.ready ? cur.se : 1'($urandom_range(0, 1));
        k++;
      end else begin
        if (bus.sel && cfg_q.size() > 0) cur = cfg_q.pop_front();
        k = 0;
        bus.ready  = 1'($urandom_range(0, 1));
        bus.rdata  = 8'($urandom);
        bus.slverr = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: bus contents, ACCESS length, latency, and response fields
  initial begin
    logic prev_rv;
    int   accn;
    exp_t h;
    prev_rv = 1'b0;
    accn = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_rv = 1'b0;
        accn = 0;
      end else begin
        if (bus.sel && exp_q.size() > 0) begin
          h = exp_q[0];
          chk("apb_addr", 32'(bus.addr), 32'(h.a));
          chk("apb_write", 32'(bus.write), 32'(h.w));
          if (h.w) chk("apb_wdata", 32'(bus.wdata), 32'(h.d));
        end
        if (bus.sel && bus.enable) accn++;
        if (bus.rsp_valid && !prev_rv) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: actual=rsp_valid required=no response (cycle %0d)", cyc);
          end else begin
            h = exp_q[0];
            chk("access_len", 32'(accn), 32'(h.acc));
            chk("rsp_latency", 32'(cyc), 32'(h.acc_at + h.acc + 1));
          end
          accn = 0;
        end
        if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
          h = exp_q.pop_front();
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(h.rdata));
          chk("rsp_err", 32'(bus.rsp_err), 32'(h.err));
          chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(h.to));
        end
        prev_rv = bus.rsp_valid;
      end
    end
  end

  // Reference: wn ready-low ACCESS cycles; wn >= T means the watchdog fires
  task automatic issue(input logic w, input logic [1:0] a, input logic [7:0] d,
                       input int wn, input logic [7:0] rd, input logic se,
                       output int acc_at);
    exp_t e;
    cfg_t c;
    int   n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 300);
    acc_at = -1;
    if (!bus.cmd_ready) begin
      fail_bound("cmd_accept");
    end else begin
      acc_at = cyc + 1;
      e.w = w;
      e.a = a;
      e.d = d;
      if (wn >= T) begin
        e.rdata = 8'h00;
        e.err   = 1'b1;
        e.to    = 1'b1;
        e.acc   = T;
      end else begin
        e.rdata = w ? 8'h00 : rd;
        e.err   = se;
        e.to    = 1'b0;
        e.acc   = wn + 1;
      end
      e.acc_at = acc_at;
      exp_q.push_back(e);
      c.wn = wn;
      c.rd = rd;
      c.se = se;
      cfg_q.push_back(c);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = 2'($urandom);
    bus.cmd_wdata = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_bound("rsp_drain");
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, 32'(bus.sel), 32'd0);
    chk({tag, "_enable"}, 32'(bus.enable), 32'd0);
    chk({tag, "_write"}, 32'(bus.write), 32'd0);
    chk({tag, "_addr"}, 32'(bus.addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int a0, a1, a2, n, seen;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 2'd0;
    bus.cmd_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    rr_mode = 0;
    issue(1'b1, 2'd1, 8'h01, 0, 8'hEE, 1'b0, a0);
    wait_done();
    issue(1'b0, 2'd0, 8'h00, 3, 8'hA5, 1'b0, a0);
    wait_done();
    issue(1'b0, 2'd2, 8'h00, 50, 8'h77, 1'b0, a0);
    wait_done();
    issue(1'b0, 2'd3, 8'h00, T, 8'h66, 1'b1, a0);
    wait_done();

    // Slave error with a stalled response consumer
    rr_mode = 2;
    issue(1'b1, 2'd3, 8'h5A, 0, 8'h00, 1'b1, a0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) fail_bound("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.cmd_valid = (i == 1);
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_err", 32'(bus.rsp_err), 32'd1);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_sel", 32'(bus.sel), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    rr_mode = 0;
    wait_done();

    // Reset while the completer is inserting wait states
    issue(1'b0, 2'd1, 8'h00, 50, 8'h11, 1'b0, a0);
    n = 0;
    while (!(bus.sel && bus.enable) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.sel && bus.enable)) fail_bound("reset_mid_access");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("mid_reset");
    chk("mid_reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    exp_q.delete();
    cfg_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("no_stale_rsp", 32'(seen), 32'd0);
    issue(1'b0, 2'd2, 8'h00, 1, 8'h3C, 1'b0, a0);
    wait_done();

    // Back-to-back commands with the consumer always ready
    issue(1'b1, 2'd0, 8'h10, 0, 8'h00, 1'b0, a0);
    issue(1'b0, 2'd1, 8'h00, 0, 8'h20, 1'b0, a1);
    issue(1'b1, 2'd2, 8'h30, 0, 8'h00, 1'b0, a2);
    chk("b2b_gap01", 32'(a1 - a0), 32'd4);
    chk("b2b_gap12", 32'(a2 - a1), 32'd4);
    wait_done();

    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
            int'($urandom_range(0, T + 2)), 8'($urandom),
            ($urandom_range(0, 3) == 0), a0);
    end
    rr_mode = 0;
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/apb_requester.md
# apb_requester

APB requester (master) that turns single commands from a local valid/ready command port into APB SETUP/ACCESS transfers. It drives one completer bus segment, such as the timer peripheral's `sel`/`enable`/`write`/`addr`/`wdata` inputs, and samples `rdata`/`ready`/`slverr`. One response is returned per command. A wait-state watchdog aborts transfers whose completer never asserts `ready`.

## Interface
- `dataBits`, default 8: width of APB and command data.
- `addrWidth`, default 2: width of APB and command address.
- `timeoutCycles`, default 16: maximum ACCESS cycles with `ready` low before abort. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  reset; **synchronous, active-low** (0 = reset, sampled on the `clk` rising edge).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when `cmd_valid` is also high.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  addrWidth  target address.
- `cmd_wdata`  in  dataBits  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  dataBits  read data.
- `rsp_err`  out  1  completer `slverr` or timeout.
- `rsp_timeout`  out  1  abort caused by the watchdog.
- `sel`  out  1  APB PSEL.
- `enable`  out  1  APB PENABLE.
- `write`  out  1  APB PWRITE.
- `addr`  out  addrWidth  APB PADDR.
- `wdata`  out  dataBits  APB PWDATA.
- `rdata`  in  dataBits  APB PRDATA.
- `ready`  in  1  APB PREADY.
- `slverr`  in  1  APB PSLVERR.

## Operation
- Four-state FSM:
  - IDLE: `cmd_ready`=1, all APB outputs idle. On `cmd_valid`: register `cmd_write`, `cmd_addr` and `cmd_wdata` into `write`/`addr`/`wdata`, then go to SETUP.
  - SETUP: `sel`=1, `enable`=0. Always goes to ACCESS next cycle.
  - ACCESS: `sel`=1, `enable`=1. `write`/`addr`/`wdata` hold stable from SETUP until the transfer ends.
    - `ready`=1: capture `rdata` (reads only; writes return 0), set `rsp_err`=`slverr`, `rsp_timeout`=0, go to RESP.
    - `ready`=0 with wait counter = `timeoutCycles`-1: set `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, go to RESP.
    - `ready`=0 otherwise: increment the wait counter and stay in ACCESS.
  - RESP: `rsp_valid`=1, `sel`=0, `enable`=0. On `rsp_ready` go to IDLE. `rsp_*` fields hold until consumed.
- `cmd_ready` is 1 only in IDLE. No command pipelining; at most one outstanding transfer.
- Wait counter:
  - Width is ceil(log2(timeoutCycles+1)).
  - Cleared on entry to SETUP; counts ACCESS cycles sampled with `ready`=0.
  - Never wraps: an abort occurs first.
- `rdata` and `slverr` are ignored except in the ACCESS cycle that samples `ready`=1.
- `slverr` on a write still produces `rsp_rdata`=0 and `rsp_err`=1.
- Undefined state encodings return to IDLE on the next edge.

## Timing
- Reset (`reset`=0 at an edge) sets:
  - state IDLE;
  - `sel`, `enable`, `write`, `addr`, `wdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` all 0;
  - wait counter 0.
- `cmd_ready` is 1 from the first edge after reset release.
- Reset mid-transfer (SETUP, ACCESS or RESP):
  - `sel`/`enable` drop to 0 at that edge.
  - The pending response is discarded and never presented.
  - `cmd_ready` is 1 after release.
- Latency with zero wait states, command accepted at edge 0:
  - SETUP visible cycle 1, ACCESS cycle 2.
  - `rsp_valid` visible cycle 3.
  - Earliest next accept is the edge after the `rsp_ready` handshake, so back-to-back throughput is 1 command per 4 cycles.
- Each wait state adds 1 cycle.
- Timeout: with `ready` held low, `rsp_valid` rises timeoutCycles+2 cycles after accept (ACCESS lasts exactly `timeoutCycles` cycles).
- `ready`=1 in the same ACCESS cycle the counter hits its limit counts as success, not timeout.
- `cmd_valid` asserted outside IDLE is ignored; the command is not accepted.

## Test plan
- Zero-wait write: `cmd` write addr=1 wdata=0x01, completer `ready`=1.
  - Required: `sel`=1 `enable`=0 for 1 cycle, then `enable`=1 for 1 cycle, `addr`=1, `wdata`=0x01.
  - `rsp_valid` at cycle 3 with `rsp_err`=0, `rsp_rdata`=0.
- Read with 3 wait states: addr=0, `ready` low for 3 ACCESS cycles then high with `rdata`=0xA5.
  - Required: ACCESS lasts 4 cycles, `addr` stable throughout, `rsp_rdata`=0xA5 at cycle 6.
- Timeout: `timeoutCycles`=4, `ready` held 0.
  - Required: ACCESS lasts exactly 4 cycles, then `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - Repeat with `ready`=1 on the 4th ACCESS cycle; required: `rsp_timeout`=0.
- Error and backpressure: write returns `slverr`=1; hold `rsp_ready`=0 for 5 cycles.
  - Required: `rsp_valid` and `rsp_err`=1 stable for 5 cycles.
  - `cmd_ready`=0 throughout; a `cmd_valid` pulse in that window is not accepted.
- Reset mid-ACCESS: pull `reset` low during a wait state.
  - Required: at the next edge `sel`=`enable`=0 and all outputs 0.
  - No `rsp_valid` after release; a fresh read then completes normally.
- Back-to-back: 3 commands queued with `rsp_ready`=1 tied high.
  - Required: accepts at cycles 0, 4, 8.
  - `sel` deasserted for ≥1 cycle between transfers.
